// File: rtl/ysyx_22050058_ex_muldiv_pkg.sv
// Shared encodings for the EX-stage multiply/divide unit: op codes, FSM states,
// stall levels and the zero word.
package ysyx_22050058_ex_muldiv_pkg;

    localparam logic [2:0] ysyx_22050058_MD_MUL    = 3'd0;
    localparam logic [2:0] ysyx_22050058_MD_MULH   = 3'd1;
    localparam logic [2:0] ysyx_22050058_MD_MULHSU = 3'd2;
    localparam logic [2:0] ysyx_22050058_MD_MULHU  = 3'd3;
    localparam logic [2:0] ysyx_22050058_MD_DIV    = 3'd4;
    localparam logic [2:0] ysyx_22050058_MD_DIVU   = 3'd5;
    localparam logic [2:0] ysyx_22050058_MD_REM    = 3'd6;
    localparam logic [2:0] ysyx_22050058_MD_REMU   = 3'd7;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    localparam logic        STALL_ENABLE  = 1'b1;
    localparam logic        STALL_DISABLE = 1'b0;
    localparam logic [63:0] ZERO_WORD     = 64'h0;

endpackage

// File: rtl/ysyx_22050058_md_divider.sv
// Iterative restoring divider on operand magnitudes: one quotient bit per cycle,
// 32 steps for W forms, XLEN steps otherwise. quot/rem show the post-step value.
module ysyx_22050058_md_divider #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            flush,
    input  logic            word,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            done,
    output logic [XLEN-1:0] quot,
    output logic [XLEN-1:0] rem
);
    logic [XLEN-1:0] quo_reg;
    logic [XLEN-1:0] rem_reg;
    logic [XLEN-1:0] div_reg;
    logic [6:0]      cnt_reg;
    logic            busy_reg;
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   trial;

    // Dividend bits are consumed from the MSB of quo_reg while quotient bits fill in at the LSB.
    assign shifted = {rem_reg, quo_reg[XLEN-1]};
    assign trial   = shifted - {1'b0, div_reg};
    assign rem     = trial[XLEN] ? shifted[XLEN-1:0] : trial[XLEN-1:0];
    assign quot    = {quo_reg[XLEN-2:0], ~trial[XLEN]};
    assign done    = busy_reg && (cnt_reg == 7'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_reg <= 1'b0;
            cnt_reg  <= '0;
            quo_reg  <= '0;
            rem_reg  <= '0;
            div_reg  <= '0;
        end else if (flush) begin
            busy_reg <= 1'b0;
        end else if (start) begin
            busy_reg <= 1'b1;
            cnt_reg  <= word ? 7'd32 : 7'(XLEN);
            quo_reg  <= word ? (dividend << (XLEN - 32)) : dividend;
            rem_reg  <= '0;
            div_reg  <= divisor;
        end else if (busy_reg) begin
            quo_reg <= quot;
            rem_reg <= rem;
            cnt_reg <= cnt_reg - 7'd1;
            if (cnt_reg == 7'd1) busy_reg <= 1'b0;
        end
    end
endmodule

// File: rtl/ysyx_22050058_ex_muldiv.sv
// Multi-cycle RV64M/RV32M execute unit: shift-add multiplier inline, restoring
// divider as a sub-core, valid/ready on both sides and a stall request while busy.
module ysyx_22050058_ex_muldiv
    import ysyx_22050058_ex_muldiv_pkg::*;
#(
    parameter int XLEN     = 64,
    parameter int FAST_MUL = 0,
    parameter int ADDR_W   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              md_valid_i,
    output logic              md_ready_o,
    input  logic [2:0]        md_op_i,
    input  logic              md_word_i,
    input  logic [XLEN-1:0]   md_op1_i,
    input  logic [XLEN-1:0]   md_op2_i,
    input  logic [ADDR_W-1:0] md_waddr_i,
    input  logic              md_flush_i,
    output logic              md_valid_o,
    input  logic              md_ready_i,
    output logic [XLEN-1:0]   md_wdata_o,
    output logic [ADDR_W-1:0] md_waddr_o,
    output logic              md_stall_req_o
);
    localparam int W2 = 2 * XLEN;

    md_state_e         state_reg;
    logic [2:0]        op_reg;
    logic              word_reg;
    logic              neg_reg;
    logic [6:0]        cnt_reg;
    logic [W2-1:0]     acc_reg;
    logic [W2-1:0]     mcand_reg;
    logic [XLEN-1:0]   mplier_reg;
    logic              valid_reg;
    logic [XLEN-1:0]   wdata_reg;
    logic [ADDR_W-1:0] waddr_reg;

    function automatic logic [XLEN-1:0] trunc_n(input logic [XLEN-1:0] x, input logic w);
        return w ? XLEN'(x[31:0]) : x;
    endfunction

    function automatic logic [XLEN-1:0] sext_n(input logic [XLEN-1:0] x, input logic w);
        return w ? XLEN'($signed(x[31:0])) : x;
    endfunction

    function automatic logic [XLEN-1:0] mul_pick(input logic [W2-1:0] prod, input logic neg,
                                                 input logic [2:0] op, input logic w);
        logic [W2-1:0] p;
        p = neg ? -prod : prod;
        if (w)                              return XLEN'($signed(p[31:0]));
        else if (op == ysyx_22050058_MD_MUL) return p[XLEN-1:0];
        else                                return p[W2-1:XLEN];
    endfunction

    // Issue-side decode, evaluated combinationally while IDLE.
    logic            word_eff, is_mul, s1, s2, neg1, neg2, res_neg, div0, ovf, fast, accept;
    logic [2:0]      op_eff;
    logic [XLEN-1:0] a_t, b_t, a_mag, b_mag, min_n, ones_n, fast_data;
    logic [W2-1:0]   prod_fast, acc_next;

    assign word_eff = (XLEN == 64) && md_word_i;
    assign is_mul   = ~md_op_i[2];
    assign op_eff   = (word_eff && is_mul) ? ysyx_22050058_MD_MUL : md_op_i;
    assign a_t      = trunc_n(md_op1_i, word_eff);
    assign b_t      = trunc_n(md_op2_i, word_eff);
    assign s1       = word_eff ? md_op1_i[31] : md_op1_i[XLEN-1];
    assign s2       = word_eff ? md_op2_i[31] : md_op2_i[XLEN-1];
    assign neg1     = s1 && (op_eff inside {ysyx_22050058_MD_MUL, ysyx_22050058_MD_MULH,
                                            ysyx_22050058_MD_MULHSU, ysyx_22050058_MD_DIV,
                                            ysyx_22050058_MD_REM});
    assign neg2     = s2 && (op_eff inside {ysyx_22050058_MD_MUL, ysyx_22050058_MD_MULH,
                                            ysyx_22050058_MD_DIV, ysyx_22050058_MD_REM});
    assign a_mag    = neg1 ? trunc_n(-a_t, word_eff) : a_t;
    assign b_mag    = neg2 ? trunc_n(-b_t, word_eff) : b_t;
    assign res_neg  = (op_eff == ysyx_22050058_MD_REM) ? neg1 : (neg1 ^ neg2);
    assign min_n    = word_eff ? XLEN'(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};
    assign ones_n   = word_eff ? XLEN'(32'hFFFF_FFFF) : '1;
    assign div0     = ~is_mul && (b_t == '0);
    assign ovf      = (op_eff == ysyx_22050058_MD_DIV || op_eff == ysyx_22050058_MD_REM)
                      && (a_t == min_n) && (b_t == ones_n);
    assign fast     = div0 || ovf || (is_mul && (FAST_MUL != 0));
    assign accept   = md_valid_i && (state_reg == MD_IDLE) && ~md_flush_i;
    assign acc_next = acc_reg + (mplier_reg[0] ? mcand_reg : '0);

    generate
        if (FAST_MUL != 0) begin : g_fast_mul
            assign prod_fast = W2'(a_mag) * W2'(b_mag);
        end else begin : g_iter_mul
            assign prod_fast = '0;
        end
    endgenerate

    // op bit 1 separates REM/REMU (6,7) from DIV/DIVU (4,5).
    always_comb begin
        fast_data = mul_pick(prod_fast, res_neg, op_eff, word_eff);
        if (div0)     fast_data = op_eff[1] ? sext_n(a_t, word_eff) : '1;
        else if (ovf) fast_data = op_eff[1] ? '0 : sext_n(a_t, word_eff);
    end

    logic            div_done;
    logic [XLEN-1:0] div_quot, div_rem, div_q_s, div_r_s, div_data;

    ysyx_22050058_md_divider #(.XLEN(XLEN)) u_divider (
        .clk      (clk),
        .rst      (rst),
        .start    (accept && ~fast && ~is_mul),
        .flush    (md_flush_i),
        .word     (word_eff),
        .dividend (a_mag),
        .divisor  (b_mag),
        .done     (div_done),
        .quot     (div_quot),
        .rem      (div_rem)
    );

    assign div_q_s  = neg_reg ? -div_quot : div_quot;
    assign div_r_s  = neg_reg ? -div_rem : div_rem;
    assign div_data = sext_n(op_reg[1] ? div_r_s : div_q_s, word_reg);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= MD_IDLE;
            op_reg     <= '0;
            word_reg   <= 1'b0;
            neg_reg    <= 1'b0;
            cnt_reg    <= '0;
            acc_reg    <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            valid_reg  <= 1'b0;
            wdata_reg  <= XLEN'(ZERO_WORD);
            waddr_reg  <= '0;
        end else begin
            case (state_reg)
                MD_IDLE: if (accept) begin
                    op_reg     <= op_eff;
                    word_reg   <= word_eff;
                    neg_reg    <= res_neg;
                    waddr_reg  <= md_waddr_i;
                    cnt_reg    <= word_eff ? 7'd32 : 7'(XLEN);
                    acc_reg    <= '0;
                    mcand_reg  <= W2'(a_mag);
                    mplier_reg <= b_mag;
                    if (fast) begin
                        wdata_reg <= fast_data;
                        valid_reg <= 1'b1;
                        state_reg <= MD_DONE;
                    end else begin
                        state_reg <= MD_CALC;
                    end
                end
                MD_CALC: begin
                    if (md_flush_i) begin
                        state_reg <= MD_IDLE;
                    end else if (op_reg[2]) begin
                        if (div_done) begin
                            wdata_reg <= div_data;
                            valid_reg <= 1'b1;
                            state_reg <= MD_DONE;
                        end
                    end else begin
                        acc_reg    <= acc_next;
                        mcand_reg  <= mcand_reg << 1;
                        mplier_reg <= mplier_reg >> 1;
                        cnt_reg    <= cnt_reg - 7'd1;
                        if (cnt_reg == 7'd1) begin
                            wdata_reg <= mul_pick(acc_next, neg_reg, op_reg, word_reg);
                            valid_reg <= 1'b1;
                            state_reg <= MD_DONE;
                        end
                    end
                end
                MD_DONE: if (md_flush_i || md_ready_i) begin
                    valid_reg <= 1'b0;
                    state_reg <= MD_IDLE;
                end
                default: begin
                    valid_reg <= 1'b0;
                    state_reg <= MD_IDLE;
                end
            endcase
        end
    end

    assign md_ready_o     = (state_reg == MD_IDLE) && !rst;
    assign md_valid_o     = valid_reg;
    assign md_wdata_o     = wdata_reg;
    assign md_waddr_o     = waddr_reg;
    assign md_stall_req_o = (!rst && ((state_reg != MD_IDLE) ||
                            (md_valid_i && state_reg == MD_IDLE && !fast)))
                            ? STALL_ENABLE : STALL_DISABLE;
endmodule

// File: tb/tb_ysyx_22050058_ex_muldiv.sv
// Randomised and directed bench for the multiply/divide unit, checked against a
// plain-arithmetic reference model and a queue of expected results.
module tb_ysyx_22050058_ex_muldiv;
    localparam logic [2:0] OP_MUL = 3'd0, OP_MULH = 3'd1, OP_MULHSU = 3'd2, OP_MULHU = 3'd3;
    localparam logic [2:0] OP_DIV = 3'd4, OP_DIVU = 3'd5, OP_REM = 3'd6, OP_REMU = 3'd7;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;

    logic clk = 1'b0, rst;
    logic md_valid_i, md_ready_o, md_word_i, md_flush_i, md_valid_o, md_ready_i, md_stall_req_o;
    logic [2:0] md_op_i;
    logic [63:0] md_op1_i, md_op2_i, md_wdata_o;
    logic [4:0] md_waddr_i, md_waddr_o;
    logic f_valid_i, f_ready_o, f_word_i, f_valid_o, f_stall;
    logic [2:0] f_op_i;
    logic [63:0] f_op1_i, f_op2_i, f_wdata_o;
    logic [4:0] f_waddr_o;

    always #5 clk = ~clk;

    ysyx_22050058_ex_muldiv #(.XLEN(64), .FAST_MUL(0), .ADDR_W(5)) dut (
        .clk(clk), .rst(rst), .md_valid_i(md_valid_i), .md_ready_o(md_ready_o),
        .md_op_i(md_op_i), .md_word_i(md_word_i), .md_op1_i(md_op1_i), .md_op2_i(md_op2_i),
        .md_waddr_i(md_waddr_i), .md_flush_i(md_flush_i), .md_valid_o(md_valid_o),
        .md_ready_i(md_ready_i), .md_wdata_o(md_wdata_o), .md_waddr_o(md_waddr_o),
        .md_stall_req_o(md_stall_req_o));

    ysyx_22050058_ex_muldiv #(.XLEN(64), .FAST_MUL(1), .ADDR_W(5)) dut_f (
        .clk(clk), .rst(rst), .md_valid_i(f_valid_i), .md_ready_o(f_ready_o),
        .md_op_i(f_op_i), .md_word_i(f_word_i), .md_op1_i(f_op1_i), .md_op2_i(f_op2_i),
        .md_waddr_i(5'd1), .md_flush_i(1'b0), .md_valid_o(f_valid_o),
        .md_ready_i(1'b1), .md_wdata_o(f_wdata_o), .md_waddr_o(f_waddr_o),
        .md_stall_req_o(f_stall));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0, bad = 0, rdy_mode = 1;
    bit seen = 0;
    typedef struct { logic [63:0] data; logic [4:0] waddr; int t_exp; } exp_t;
    exp_t q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] sx32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    // Reference: RISC-V M-extension semantics from plain integer arithmetic.
    function automatic logic [63:0] model(input logic [2:0] op, input logic w,
                                          input logic [63:0] a, input logic [63:0] b);
        logic signed [127:0] pa, pb, p;
        logic [31:0] a32, b32, r32;
        a32 = a[31:0];
        b32 = b[31:0];
        if (w) begin
            case (op)
                OP_DIV:  if (b32 == 0) return ONES;
                         else if (a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) return sx32(a32);
                         else begin r32 = $signed(a32) / $signed(b32); return sx32(r32); end
                OP_DIVU: if (b32 == 0) return ONES; else begin r32 = a32 / b32; return sx32(r32); end
                OP_REM:  if (b32 == 0) return sx32(a32);
                         else if (a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) return 64'd0;
                         else begin r32 = $signed(a32) % $signed(b32); return sx32(r32); end
                OP_REMU: if (b32 == 0) return sx32(a32); else begin r32 = a32 % b32; return sx32(r32); end
                default: begin r32 = a32 * b32; return sx32(r32); end
            endcase
        end
        case (op)
            OP_MUL:    return a * b;
            OP_MULH:   begin pa = $signed(a); pb = $signed(b); p = pa * pb; return p[127:64]; end
            OP_MULHSU: begin pa = $signed(a); pb = {64'd0, b}; p = pa * pb; return p[127:64]; end
            OP_MULHU:  begin pa = {64'd0, a}; pb = {64'd0, b}; p = pa * pb; return p[127:64]; end
            OP_DIV:    if (b == 0) return ONES; else if (a == MINV && b == ONES) return a;
                       else return $signed(a) / $signed(b);
            OP_DIVU:   if (b == 0) return ONES; else return a / b;
            OP_REM:    if (b == 0) return a; else if (a == MINV && b == ONES) return 64'd0;
                       else return $signed(a) % $signed(b);
            default:   if (b == 0) return a; else return a % b;
        endcase
    endfunction

    function automatic int lat_of(input logic [2:0] op, input logic w,
                                  input logic [63:0] a, input logic [63:0] b);
        if (op >= OP_DIV) begin
            if (w ? (b[31:0] == 0) : (b == 0)) return 1;
            if ((op == OP_DIV || op == OP_REM) &&
                (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) : (a == MINV && b == ONES)))
                return 1;
        end
        return w ? 33 : 65;
    endfunction

    function automatic logic [63:0] rnd_op();
        case ($urandom_range(0, 9))
            0: return 64'd0;
            1: return ONES;
            2: return MINV;
            3: return {$urandom(), 32'h8000_0000};
            4: return 64'($urandom_range(0, 20));
            5: return {$urandom(), 32'hFFFF_FFFF};
            default: return {$urandom(), $urandom()};
        endcase
    endfunction

    // Compare process: every cycle valid_o is high it must match the queue head.
    initial forever begin
        @(negedge clk);
        if (!rst && md_valid_o) begin
            if (q.size() == 0) begin
                total++; bad++;
                $display("FAIL spurious_valid: got wdata %h want no result (cycle %0d)", md_wdata_o, cyc);
            end else begin
                if (!seen) chk("latency", 64'(cyc), 64'(q[0].t_exp));
                chk("wdata", md_wdata_o, q[0].data);
                chk("waddr", 64'(md_waddr_o), 64'(q[0].waddr));
                seen = 1;
                if (md_ready_i) begin void'(q.pop_front()); seen = 0; end
            end
        end
    end

    initial begin
        md_ready_i = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0: md_ready_i = ($urandom_range(0, 3) != 0);
                1: md_ready_i = 1'b1;
                default: md_ready_i = 1'b0;
            endcase
        end
    end

    task automatic issue(input logic [2:0] op, input logic w, input logic [63:0] a,
                         input logic [63:0] b, input logic [4:0] wa, input logic [63:0] exp,
                         input bit push, output int t, output logic st);
        int n = 0;
        while (!md_ready_o && n < 300) begin @(posedge clk); #2; n++; end
        if (!md_ready_o) begin
            total++; bad++;
            $display("FAIL ready_timeout: got ready_o 0 want 1 (cycle %0d)", cyc);
        end
        md_valid_i = 1; md_op_i = op; md_word_i = w; md_op1_i = a; md_op2_i = b; md_waddr_i = wa;
        t = cyc;
        if (push) q.push_back('{exp, wa, t + lat_of(op, w, a, b)});
        #1 st = md_stall_req_o;
        @(posedge clk); #2;
        md_valid_i = 0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 400) begin @(posedge clk); #2; n++; end
        if (q.size() != 0) begin
            total++; bad++;
            $display("FAIL drain_timeout: got %0d pending want 0", q.size());
            q.delete();
        end
    endtask

    task automatic run_dir(input logic [2:0] op, input logic w, input logic [63:0] a,
                           input logic [63:0] b, input logic [63:0] exp, input logic exp_st);
        int t; logic st;
        chk("pin_model", model(op, w, a, b), exp);
        issue(op, w, a, b, 5'($urandom_range(0, 31)), exp, 1, t, st);
        chk("stall_at_accept", 64'(st), 64'(exp_st));
        drain();
    endtask

    task automatic fast_mul(input logic [2:0] op, input logic w, input logic [63:0] a,
                            input logic [63:0] b, input logic [63:0] exp);
        f_valid_i = 1; f_op_i = op; f_word_i = w; f_op1_i = a; f_op2_i = b;
        #1 chk("fast_stall", 64'(f_stall), 64'd0);
        @(posedge clk); #1;
        chk("fast_valid", 64'(f_valid_o), 64'd1);
        chk("fast_wdata", f_wdata_o, exp);
        f_valid_i = 0;
        @(posedge clk); #2;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t; logic st; bit ok;
        logic [63:0] hd; logic [4:0] ha; logic [2:0] op; logic w; logic [63:0] a, b;
        rst = 1; md_valid_i = 0; md_op_i = 0; md_word_i = 0; md_op1_i = 0; md_op2_i = 0;
        md_waddr_i = 0; md_flush_i = 0;
        f_valid_i = 0; f_op_i = 0; f_word_i = 0; f_op1_i = 0; f_op2_i = 0;
        repeat (3) @(posedge clk);
        #2 chk("rst_valid", 64'(md_valid_o), 64'd0);
        chk("rst_stall", 64'(md_stall_req_o), 64'd0);
        rst = 0;
        @(posedge clk); #2;
        chk("reset_ready", 64'(md_ready_o), 64'd1);
        chk("reset_valid", 64'(md_valid_o), 64'd0);
        chk("reset_wdata", md_wdata_o, 64'd0);
        chk("reset_waddr", 64'(md_waddr_o), 64'd0);

        // MUL 3 * -5 with the stall window over the whole CALC phase
        chk("pin_model", model(OP_MUL, 0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB), 64'hFFFF_FFFF_FFFF_FFF1);
        issue(OP_MUL, 0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 5'd3, 64'hFFFF_FFFF_FFFF_FFF1, 1, t, st);
        chk("stall_at_accept", 64'(st), 64'd1);
        ok = 1;
        for (int i = 0; i < 64; i++) begin
            if (md_stall_req_o !== 1'b1) ok = 0;
            @(posedge clk); #2;
        end
        chk("stall_window", 64'(ok), 64'd1);
        drain();

        run_dir(OP_MULHU, 0, ONES, 64'd2, 64'd1, 1);
        run_dir(OP_MULHSU, 0, ONES, 64'd2, ONES, 1);
        run_dir(OP_DIVU, 0, 64'd7, 64'd0, ONES, 0);
        run_dir(OP_REM, 0, 64'd7, 64'd0, 64'd7, 0);
        run_dir(OP_DIV, 0, MINV, ONES, MINV, 0);
        run_dir(OP_REM, 0, MINV, ONES, 64'd0, 0);
        run_dir(OP_DIV, 1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1);
        run_dir(OP_REMU, 1, 64'h1_0000_0007, 64'd2, 64'd1, 1);
        run_dir(OP_REM, 1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, ONES, 1);
        run_dir(OP_DIV, 1, 64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 0);

        // Backpressure: result must hold while ready_i is low
        rdy_mode = 2;
        @(posedge clk); #2;
        issue(OP_MUL, 0, 64'd12345, 64'd678, 5'd9, 64'd8369910, 1, t, st);
        for (int n = 0; n < 100 && !md_valid_o; n++) begin @(posedge clk); #2; end
        hd = md_wdata_o; ha = md_waddr_o;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold", {md_valid_o, md_ready_o, md_wdata_o == hd, md_waddr_o == ha},
                {1'b1, 1'b0, 1'b1, 1'b1});
        end
        rdy_mode = 1;
        @(posedge clk); @(posedge clk); #2;
        chk("bp_release_ready", 64'(md_ready_o), 64'd1);
        drain();

        // Flush at T+10 of a DIV: no result, ready back at T+11
        issue(OP_DIV, 0, 64'd100, 64'd7, 5'd4, 64'd0, 0, t, st);
        while (cyc < t + 10) begin @(posedge clk); #2; end
        md_flush_i = 1;
        @(posedge clk); #2;
        md_flush_i = 0;
        chk("flush_ready", 64'(md_ready_o), 64'd1);
        ok = 1;
        for (int i = 0; i < 70; i++) begin
            if (md_valid_o) ok = 0;
            @(posedge clk); #2;
        end
        chk("flush_no_valid", 64'(ok), 64'd0 + 64'd1);

        // Asynchronous reset mid-CALC, then a fresh MUL
        issue(OP_MUL, 0, 64'd77, 64'd99, 5'd7, 64'd0, 0, t, st);
        repeat (20) @(posedge clk);
        #2 chk("pre_rst_stall", 64'(md_stall_req_o), 64'd1);
        rst = 1;
        #1;
        chk("async_rst_out", {md_valid_o, md_stall_req_o, md_waddr_o, md_wdata_o}, 64'd0);
        @(posedge clk); #2;
        rst = 0;
        @(posedge clk); #2;
        chk("post_rst_ready", 64'(md_ready_o), 64'd1);
        issue(OP_MUL, 0, 64'd77, 64'd99, 5'd7, 64'd7623, 1, t, st);
        drain();

        // FAST_MUL instance: product in T+1
        fast_mul(OP_MULHU, 0, ONES, 64'd2, 64'd1);
        for (int i = 0; i < 20; i++) begin
            op = 3'($urandom_range(0, 3)); w = 1'($urandom_range(0, 1)); a = rnd_op(); b = rnd_op();
            fast_mul(op, w, a, b, model(op, w, a, b));
        end

        // Randomised traffic with random downstream backpressure
        rdy_mode = 0;
        for (int i = 0; i < 250; i++) begin
            op = 3'($urandom_range(0, 7)); w = 1'($urandom_range(0, 1)); a = rnd_op(); b = rnd_op();
            issue(op, w, a, b, 5'($urandom_range(0, 31)), model(op, w, a, b), 1, t, st);
        end
        drain();
        rdy_mode = 1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ysyx_22050058_ex_muldiv.md
Name: ysyx_22050058_ex_muldiv

Overview:
Parametrised multi-cycle RV64M/RV32M execute unit sitting beside the single-cycle ALU in the EX stage; handles MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU and their W forms.
Iterative shift-add multiplier and restoring divider, one bit per cycle, with an optional single-cycle multiply mode.
Valid/ready on both sides; holds the CtrlBlock stall request while busy. Write-back data goes to MemStage via the EX mux.

Parameters:
XLEN, 64, datapath width (32 or 64)
FAST_MUL, 0, 1 = multiply computed with a single-cycle product in IDLE; 0 = iterative
ADDR_W, 5, register write address width

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
md_valid_i  in  1  operation offered by ID/EX
md_ready_o  out  1  unit can accept (high only in IDLE)
md_op_i  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
md_word_i  in  1  W-form: use low 32 bits, sign-extend result (XLEN=64 only)
md_op1_i  in  XLEN  rs1 value
md_op2_i  in  XLEN  rs2 value
md_waddr_i  in  ADDR_W  destination register
md_flush_i  in  1  kill in-flight operation
md_valid_o  out  1  result available
md_ready_i  in  1  downstream accepts result
md_wdata_o  out  XLEN  result
md_waddr_o  out  ADDR_W  destination register of result
md_stall_req_o  out  1  stall request to CtrlBlock

Behaviour:
- Reset (async, any state): state=IDLE; md_valid_o=0, md_wdata_o=0, md_waddr_o=0, md_stall_req_o=0; md_ready_o=1 after reset release.
- FSM: IDLE, CALC, DONE.
- IDLE: ready_o=1. Accept on valid_i&ready_o at cycle T: latch op, word, waddr, operand magnitudes, result sign; N=32 if word_i else XLEN.
- Result sign: MUL*/DIV: sign(op1)^sign(op2); MULHSU: sign(op1) only; MULHU/DIVU/REMU: positive; REM: sign(op1). W forms use bit 31 as the sign bit.
- Fast paths, IDLE->DONE (valid_o in T+1): divisor==0 (DIV/DIVU quotient all-ones, REM/REMU = dividend); signed overflow, most-negative/-1 (DIV quotient = dividend, REM = 0); multiply when FAST_MUL=1.
- CALC: counter = N, decremented each cycle; after N cycles go to DONE, so valid_o rises in cycle T+N+1.
- Multiply: 2N-bit accumulator of magnitudes, negated at finish if the sign bit is set. MUL returns the low N bits; MULH* return the high N bits.
- Divide: restoring, one quotient bit per cycle, then sign correction of quotient and remainder.
- W forms: operands truncated to 32 bits; result bit 31 sign-extended to XLEN.
- md_word_i with op 1-3 is never issued by the decoder; the unit treats it as MULW.
- DONE: valid_o=1; wdata_o and waddr_o stable while ready_i=0. On valid_o&ready_i go to IDLE; no back-to-back accept in the same cycle.
- md_stall_req_o = (state!=IDLE) | (md_valid_i & state==IDLE & not a fast path).
- md_flush_i in CALC or DONE: IDLE next cycle, valid_o=0, no result ever emitted. flush_i in IDLE blocks the accept that cycle. Flush has priority over accept and completion.
- XLEN=32: md_word_i is ignored and treated as 0.

Decomposition:
- Shared package/define file: md op encodings (ysyx_22050058_MD_*), FSM state encodings, StallEnable/StallDisable, ZeroWord.
- One natural sub-module: ysyx_22050058_md_divider (iterative restoring divider core with start/done). The multiplier stays inline.

Test Plan:
- MUL, XLEN=64, FAST_MUL=0: op1=3, op2=0xFFFF_FFFF_FFFF_FFFB -> wdata=0xFFFF_FFFF_FFFF_FFF1; valid_o first high at T+65; stall_req high T..T+64.
- MULHU op1=0xFFFF_FFFF_FFFF_FFFF, op2=2 -> 0x1. With FAST_MUL=1, same operands -> 0x1 at T+1.
- DIVU 7/0 -> 0xFFFF_FFFF_FFFF_FFFF at T+1; REM 7/0 -> 7. DIV 0x8000_0000_0000_0000/-1 -> 0x8000_0000_0000_0000; REM of the same operands -> 0.
- DIVW op1=0xFFFF_FFFF_FFFF_FFF9 (-7), op2=2 -> 0xFFFF_FFFF_FFFF_FFFD at T+33. REMUW op1=0x1_0000_0007, op2=2 -> 0x1. REMW -7/2 -> 0xFFFF_FFFF_FFFF_FFFF.
- Backpressure: hold ready_i=0 for 5 cycles in DONE -> valid_o, wdata_o, waddr_o unchanged and ready_o=0; release ready_i -> IDLE next cycle with ready_o=1.
- Flush at T+10 of a DIV -> valid_o never high, ready_o=1 at T+11. Async rst asserted mid-CALC -> all outputs 0 immediately; a new MUL after release completes correctly.
